// File: rtl/seven_seg_rx_pkg.sv
// Shared definitions for the seven-segment link receiver: glyph table,
// receiver FSM states and the default strobe period.
package seven_seg_rx_pkg;

    // Nominal strobe period of the multiplexed link, in clk cycles.
    localparam int FREQ_DEFAULT = 40000;

    // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F, index = nibble.
    localparam logic [6:0] GLYPH_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Which digit the next accepted strobe carries.
    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } rx_state_t;

endpackage

// File: rtl/seven_seg_rx_if.sv
// Frame output bundle of the receiver: reassembled patterns, decoded
// nibbles, valid/ready handshake and link status flags.
interface seven_seg_rx_if;
    import seven_seg_rx_pkg::*;

    logic [13:0] both7seg;
    logic [3:0]  hi_nib;
    logic [3:0]  lo_nib;
    logic        hi_ok;
    logic        lo_ok;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        link_lost;

    // Receiver side drives the frame, consumer returns ready.
    modport master (
        output both7seg, hi_nib, lo_nib, hi_ok, lo_ok,
        output out_valid, overrun, link_lost,
        input  out_ready
    );

    modport slave (
        input  both7seg, hi_nib, lo_nib, hi_ok, lo_ok,
        input  out_valid, overrun, link_lost,
        output out_ready
    );
endinterface

// File: rtl/seven_seg_rx_seg7_to_hex.sv
// Combinational glyph decoder: a 7-bit segment pattern to a hex nibble,
// with ok=0 and nibble 0 for anything that is not a hex glyph.
module seg7_to_hex
    import seven_seg_rx_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] nib_o,
    output logic       ok_o
);

    // Table search; at most one entry can match since glyphs are distinct.
    always_comb begin
        nib_o = 4'h0;
        ok_o  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat_i == GLYPH_TABLE[i]) begin
                nib_o = 4'(i);
                ok_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_rx.sv
// Receiver for a two-digit multiplexed seven-segment link: captures the hi
// and lo digit on successive sig rising edges, decodes both and presents the
// frame through a valid/ready handshake, with overrun and link-loss status.
module seven_seg_rx
    import seven_seg_rx_pkg::*;
#(
    parameter int FREQ    = FREQ_DEFAULT,
    parameter int TIMEOUT = 3 * FREQ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       sig,
    seven_seg_rx_if.master bus
);

    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);

    logic            sig_q;
    rx_state_t       state_q;
    logic [6:0]      hi_pat_q;
    logic [CW-1:0]   idle_q;
    logic [CW-1:0]   idle_d;
    logic [13:0]     both7seg_q;
    logic [3:0]      hi_nib_q;
    logic [3:0]      lo_nib_q;
    logic            hi_ok_q;
    logic            lo_ok_q;
    logic            out_valid_q;
    logic            overrun_q;

    logic            strobe;
    logic            lost;
    rx_state_t       cur_state;
    logic            complete;
    logic [3:0]      hi_nib_dec;
    logic [3:0]      lo_nib_dec;
    logic            hi_ok_dec;
    logic            lo_ok_dec;

    // A held-high sig counts once; link loss overrides the stored state so a
    // strobe arriving while lost is always taken as a hi digit.
    assign strobe    = sig & ~sig_q;
    assign lost      = (idle_q == TIMEOUT_C);
    assign cur_state = lost ? WAIT_HI : state_q;
    assign complete  = strobe && (cur_state == WAIT_LO);

    // Hi digit decodes from the stored pattern, lo digit straight off the bus
    // so both are ready to be registered in the completion cycle.
    seg7_to_hex u_dec_hi (
        .pat_i (hi_pat_q),
        .nib_o (hi_nib_dec),
        .ok_o  (hi_ok_dec)
    );

    seg7_to_hex u_dec_lo (
        .pat_i (seg_in),
        .nib_o (lo_nib_dec),
        .ok_o  (lo_ok_dec)
    );

    // Idle counter next value: cleared by a strobe, otherwise saturating.
    always_comb begin
        idle_d = idle_q;
        if (strobe)
            idle_d = '0;
        else if (!lost)
            idle_d = idle_q + 1'b1;
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (rst)
            idle_q <= '0;
        else
            idle_q <= idle_d;
    end

    // Digit-capture FSM with registered frame outputs and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q       <= 1'b0;
            state_q     <= WAIT_HI;
            hi_pat_q    <= '0;
            both7seg_q  <= '0;
            hi_nib_q    <= '0;
            lo_nib_q    <= '0;
            hi_ok_q     <= 1'b0;
            lo_ok_q     <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sig_q     <= sig;
            overrun_q <= 1'b0;
            if (strobe) begin
                case (cur_state)
                    WAIT_HI: begin
                        hi_pat_q <= seg_in;
                        state_q  <= WAIT_LO;
                    end
                    WAIT_LO: begin
                        both7seg_q  <= {hi_pat_q, seg_in};
                        hi_nib_q    <= hi_nib_dec;
                        lo_nib_q    <= lo_nib_dec;
                        hi_ok_q     <= hi_ok_dec;
                        lo_ok_q     <= lo_ok_dec;
                        out_valid_q <= 1'b1;
                        overrun_q   <= out_valid_q & ~bus.out_ready;
                        state_q     <= WAIT_HI;
                    end
                    default: state_q <= WAIT_HI;
                endcase
            end else if (lost) begin
                state_q  <= WAIT_HI;
                hi_pat_q <= '0;
            end
            if (!complete && out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;
        end
    end

    assign bus.both7seg  = both7seg_q;
    assign bus.hi_nib    = hi_nib_q;
    assign bus.lo_nib    = lo_nib_q;
    assign bus.hi_ok     = hi_ok_q;
    assign bus.lo_ok     = lo_ok_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.link_lost = lost;

endmodule

// File: tb/tb_seven_seg_rx.sv
// Self-checking bench for seven_seg_rx: directed scenarios followed by
// random traffic, every cycle compared against a behavioural frame model.
module tb_seven_seg_rx;

    localparam int FREQ    = 8;
    localparam int TIMEOUT = 24;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = '0;
    logic       sig = 1'b0;

    seven_seg_rx_if bus ();

    seven_seg_rx #(.FREQ(FREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .seg_in (seg_in),
        .sig    (sig),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frames = 0;

    // Reference model state.
    logic        m_prev_sig = 1'b0;
    int          m_idle     = 0;
    logic        m_have_hi  = 1'b0;
    logic [6:0]  m_hi       = '0;
    logic [13:0] m_frame    = '0;
    logic [3:0]  m_hi_nib   = '0;
    logic [3:0]  m_lo_nib   = '0;
    logic        m_hi_ok    = 1'b0;
    logic        m_lo_ok    = 1'b0;
    logic        m_valid    = 1'b0;
    logic        m_ovr      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void glyph_lookup(input logic [6:0] p, output logic [3:0] n, output logic ok);
        n  = 4'h0;
        ok = 1'b0;
        foreach (HEX_GLYPH[i]) begin
            if (HEX_GLYPH[i] == p) begin
                n  = 4'(i);
                ok = 1'b1;
            end
        end
    endfunction

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_step(input logic r, input logic s, input logic [6:0] seg, input logic rdy);
        logic strobe;
        logic lost_before;
        if (r) begin
            m_prev_sig = 1'b0; m_idle = 0; m_have_hi = 1'b0; m_hi = '0;
            m_frame = '0; m_hi_nib = '0; m_lo_nib = '0; m_hi_ok = 1'b0;
            m_lo_ok = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
            return;
        end
        strobe      = s && !m_prev_sig;
        m_prev_sig  = s;
        lost_before = (m_idle >= TIMEOUT);
        m_ovr       = 1'b0;
        if (lost_before) m_have_hi = 1'b0;
        if (strobe && m_have_hi) begin
            m_ovr   = m_valid && !rdy;
            m_frame = {m_hi, seg};
            glyph_lookup(m_hi, m_hi_nib, m_hi_ok);
            glyph_lookup(seg, m_lo_nib, m_lo_ok);
            m_valid   = 1'b1;
            m_have_hi = 1'b0;
            frames++;
            $display("frame %0d: hi=%02h lo=%02h ready=%0b overrun=%0b",
                     frames, m_hi, seg, rdy, m_ovr);
        end else begin
            if (strobe) begin
                m_hi      = seg;
                m_have_hi = 1'b1;
            end
            if (m_valid && rdy) m_valid = 1'b0;
        end
        m_idle = strobe ? 0 : ((m_idle + 1 > TIMEOUT) ? TIMEOUT : m_idle + 1);
    endtask

    task automatic compare_all();
        chk("both7seg",  32'(bus.both7seg),  32'(m_frame));
        chk("hi_nib",    32'(bus.hi_nib),    32'(m_hi_nib));
        chk("lo_nib",    32'(bus.lo_nib),    32'(m_lo_nib));
        chk("hi_ok",     32'(bus.hi_ok),     32'(m_hi_ok));
        chk("lo_ok",     32'(bus.lo_ok),     32'(m_lo_ok));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("overrun",   32'(bus.overrun),   32'(m_ovr));
        chk("link_lost", 32'(bus.link_lost), 32'(m_idle == TIMEOUT));
    endtask

    // One clock: apply inputs, clock, update model, sample 1 time unit later.
    task automatic step(input logic r, input logic s, input logic [6:0] seg, input logic rdy);
        rst           = r;
        sig           = s;
        seg_in        = seg;
        bus.out_ready = rdy;
        @(posedge clk);
        model_step(r, s, seg, rdy);
        #1;
        compare_all();
    endtask

    // Strobe one digit: one cycle high, one cycle low.
    task automatic send(input logic [6:0] seg, input logic rdy);
        step(1'b0, 1'b1, seg, rdy);
        step(1'b0, 1'b0, 7'h00, rdy);
    endtask

    initial begin
        bus.out_ready = 1'b0;

        // Reset state, including a strobe coincident with reset.
        step(1'b1, 1'b0, 7'h00, 1'b0);
        step(1'b1, 1'b1, 7'h06, 1'b0);
        step(1'b1, 1'b0, 7'h00, 1'b0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_frame", 32'(bus.both7seg), 32'd0);

        // Basic frame 0x06 / 0x5B.
        send(7'h06, 1'b0);
        chk("pre_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b1, 7'h5B, 1'b0);
        chk("f1_frame", 32'(bus.both7seg), 32'h035B);
        chk("f1_hi_nib", 32'(bus.hi_nib), 32'd1);
        chk("f1_lo_nib", 32'(bus.lo_nib), 32'd2);
        chk("f1_valid", 32'(bus.out_valid), 32'd1);
        step(1'b0, 1'b0, 7'h00, 1'b1);

        // Non-glyph hi digit.
        send(7'h00, 1'b0);
        send(7'h3F, 1'b0);
        chk("blank_hi_ok", 32'(bus.hi_ok), 32'd0);
        chk("blank_lo_ok", 32'(bus.lo_ok), 32'd1);

        // Two frames unconsumed -> overrun; then completion with ready -> none.
        send(7'h07, 1'b0);
        step(1'b0, 1'b1, 7'h7F, 1'b0);
        chk("ovr_pulse", 32'(bus.overrun), 32'd1);
        step(1'b0, 1'b0, 7'h00, 1'b0);
        chk("ovr_clear", 32'(bus.overrun), 32'd0);
        chk("ovr_held", 32'(bus.both7seg), 32'({7'h07, 7'h7F}));
        send(7'h77, 1'b1);
        step(1'b0, 1'b1, 7'h7C, 1'b1);
        chk("rdy_no_ovr", 32'(bus.overrun), 32'd0);
        chk("rdy_valid", 32'(bus.out_valid), 32'd1);
        step(1'b0, 1'b0, 7'h00, 1'b1);

        // sig held high for 5 cycles counts once.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 7'h66, 1'b1);
        step(1'b0, 1'b0, 7'h00, 1'b1);
        send(7'h6D, 1'b1);
        chk("held_frame", 32'(bus.both7seg), 32'({7'h66, 7'h6D}));

        // Hi strobe then TIMEOUT idle cycles -> link lost, next pair is hi/lo.
        step(1'b0, 1'b1, 7'h07, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) step(1'b0, 1'b0, 7'h00, 1'b0);
        chk("lost_set", 32'(bus.link_lost), 32'd1);
        step(1'b0, 1'b1, 7'h3F, 1'b0);
        chk("lost_clear", 32'(bus.link_lost), 32'd0);
        step(1'b0, 1'b0, 7'h00, 1'b0);
        step(1'b0, 1'b1, 7'h71, 1'b0);
        chk("relink_frame", 32'(bus.both7seg), 32'h1FF1);

        // Reset between hi and lo strobes.
        send(7'h06, 1'b0);
        step(1'b1, 1'b0, 7'h00, 1'b0);
        chk("midrst_frame", 32'(bus.both7seg), 32'd0);
        send(7'h4F, 1'b0);
        send(7'h66, 1'b0);
        chk("midrst_next", 32'(bus.both7seg), 32'({7'h4F, 7'h66}));

        // Random traffic with occasional long gaps and resets.
        for (int n = 0; n < 3000; n++) begin
            logic       r, s, rdy;
            logic [6:0] seg;
            if (n % 400 == 399) begin
                for (int k = 0; k < TIMEOUT + 3; k++) step(1'b0, 1'b0, 7'h00, 1'($urandom_range(0, 1)));
            end
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 2) == 0);
            seg = ($urandom_range(0, 3) != 0) ? HEX_GLYPH[$urandom_range(0, 15)] : 7'($urandom);
            rdy = 1'($urandom_range(0, 1));
            step(r, s, seg, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
